// File: rtl/mem_wb_stage.sv
// MEM stage and MEM/WB register: runs loads/stores over a req/ack port and stalls upstream while busy.
// Define MEM_STALL_CNT_EN to add the saturating stall-cycle counter output stall_cnt_o.
module mem_wb_stage #(
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 16
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [1:0]  WB_i,
  input  logic [2:0]  M_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_i,
  input  logic [4:0]  rd_i,
  output logic        stall_o,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_ack_i,
  input  logic [31:0] dmem_rdata_i,
  output logic [1:0]  WB_o,
  output logic [31:0] rdata_o,
  output logic [31:0] alu_o,
  output logic [4:0]  rd_o,
  output logic        err_o
`ifdef MEM_STALL_CNT_EN
  , output logic [CNT_W-1:0] stall_cnt_o
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_e;

  state_e        state_q, state_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          req_q, req_d, we_q, we_d, err_q, err_d;
  logic [31:0]   addr_q, addr_d, wdata_q, wdata_d;
  logic [1:0]    wb_q, wb_d;
  logic [31:0]   rdata_q, rdata_d, alu_q, alu_d;
  logic [4:0]    rd_q, rd_d;
  logic          stall_c, memop;
  logic          unused_m2;

  assign memop     = M_i[1] | M_i[0];
  assign unused_m2 = M_i[2];

  always_comb begin
    state_d = state_q;
    tmo_d   = tmo_q;
    stall_c = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    wb_d    = wb_q;
    rdata_d = rdata_q;
    alu_d   = alu_q;
    rd_d    = rd_q;
    case (state_q)
      IDLE: begin
        if (memop) begin
          stall_c = 1'b1;
          wb_d    = '0;
          rd_d    = '0;
          alu_d   = '0;
          rdata_d = '0;
          we_d    = M_i[0];
          addr_d  = addr_i;
          wdata_d = data_i;
          req_d   = 1'b1;
          tmo_d   = '0;
          state_d = BUSY;
        end else begin
          wb_d    = WB_i;
          rd_d    = rd_i;
          alu_d   = addr_i;
          rdata_d = '0;
        end
      end
      BUSY: begin
        if (dmem_ack_i) begin
          wb_d    = WB_i;
          rd_d    = rd_i;
          alu_d   = addr_i;
          rdata_d = we_q ? 32'h0 : dmem_rdata_i;
          req_d   = 1'b0;
          state_d = IDLE;
        end else if (tmo_q == TMO_LAST) begin
          // Abort: retire the instruction without a register write
          wb_d    = '0;
          rd_d    = rd_i;
          alu_d   = addr_i;
          rdata_d = '0;
          req_d   = 1'b0;
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          stall_c = 1'b1;
          wb_d    = '0;
          rd_d    = '0;
          alu_d   = '0;
          rdata_d = '0;
          tmo_d   = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      wb_q    <= '0;
      rdata_q <= '0;
      alu_q   <= '0;
      rd_q    <= '0;
    end else begin
      state_q <= state_d;
      tmo_q   <= tmo_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      wb_q    <= wb_d;
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      rd_q    <= rd_d;
    end
  end

  // Held low through reset so upstream is never frozen by a stale BUSY state
  assign stall_o      = stall_c & ~rst_i;
  assign dmem_req_o   = req_q;
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign WB_o         = wb_q;
  assign rdata_o      = rdata_q;
  assign alu_o        = alu_q;
  assign rd_o         = rd_q;
  assign err_o        = err_q;

`ifdef MEM_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_o && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  localparam int unsigned UNUSED_CNT_W = CNT_W;
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: transaction-level model checked every cycle plus directed literal checks.
module tb_mem_wb_stage;
  localparam int unsigned TIMEOUT = 16;
  localparam int unsigned CNT_W   = 16;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [1:0]  WB_i;
  logic [2:0]  M_i;
  logic [31:0] addr_i, data_i;
  logic [4:0]  rd_i;
  logic        stall_o, dmem_req_o, dmem_we_o;
  logic [31:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i;
  logic [31:0] dmem_rdata_i;
  logic [1:0]  WB_o;
  logic [31:0] rdata_o, alu_o;
  logic [4:0]  rd_o;
  logic        err_o;
`ifdef MEM_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_o;
`endif

  mem_wb_stage #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .WB_i(WB_i), .M_i(M_i), .addr_i(addr_i),
    .data_i(data_i), .rd_i(rd_i), .stall_o(stall_o), .dmem_req_o(dmem_req_o),
    .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
    .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i), .WB_o(WB_o),
    .rdata_o(rdata_o), .alu_o(alu_o), .rd_o(rd_o), .err_o(err_o)
`ifdef MEM_STALL_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Model: an access is "open" from the memop cycle until it retires; m_wait = BUSY cycles seen
  bit          m_ready = 0;
  bit          m_open  = 0;
  int          m_wait  = 0;
  bit          e_full, e_req, e_we, e_err;
  logic [1:0]  e_wb;
  logic [4:0]  e_rd;
  logic [31:0] e_alu, e_rdata, e_addr, e_wdata;
  longint      m_cnt = 0;

  function automatic bit model_stall();
    bit mop;
    mop = M_i[1] | M_i[0];
    if (rst_i) return 1'b0;
    if (!m_open) return mop;
    return !dmem_ack_i && ((m_wait + 1) < TIMEOUT);
  endfunction

  always @(posedge clk_i) begin
    if (rst_i) begin
      m_open = 0; m_wait = 0; m_cnt = 0;
      e_full = 1; e_req = 0; e_we = 0; e_err = 0;
      e_wb = 0; e_rd = 0; e_alu = 0; e_rdata = 0; e_addr = 0; e_wdata = 0;
      m_ready = 1;
    end else if (m_ready) begin
      if (model_stall() && m_cnt < (64'd1 << CNT_W) - 1) m_cnt++;
      if (!m_open) begin
        if (M_i[1] | M_i[0]) begin
          e_wb = 0; e_rd = 0; e_full = 0;
          e_req = 1; e_we = M_i[0]; e_addr = addr_i; e_wdata = data_i;
          m_open = 1; m_wait = 0;
        end else begin
          e_wb = WB_i; e_rd = rd_i; e_alu = addr_i; e_rdata = 0; e_full = 1;
        end
      end else begin
        m_wait++;
        if (dmem_ack_i) begin
          e_wb = WB_i; e_rd = rd_i; e_alu = addr_i; e_full = 1;
          e_rdata = e_we ? 32'h0 : dmem_rdata_i;
          e_req = 0; m_open = 0;
        end else if (m_wait == TIMEOUT) begin
          e_wb = 0; e_rd = rd_i; e_alu = addr_i; e_rdata = 0; e_full = 1;
          e_req = 0; e_err = 1; m_open = 0;
        end else begin
          e_wb = 0; e_rd = 0; e_full = 0;
        end
      end
    end
  end

  always @(negedge clk_i) begin
    if (m_ready) begin
      chk("m_stall", stall_o, model_stall());
      chk("m_req", dmem_req_o, e_req);
      chk("m_wb", WB_o, e_wb);
      chk("m_rd", rd_o, e_rd);
      chk("m_err", err_o, e_err);
      if (e_full) begin
        chk("m_alu", alu_o, e_alu);
        chk("m_rdata", rdata_o, e_rdata);
      end
      if (e_req) begin
        chk("m_we", dmem_we_o, e_we);
        chk("m_addr", dmem_addr_o, e_addr);
        chk("m_wdata", dmem_wdata_o, e_wdata);
      end
`ifdef MEM_STALL_CNT_EN
      chk("m_cnt", stall_cnt_o, m_cnt[31:0]);
`endif
    end
  end

  task automatic step();
    @(posedge clk_i);
    #2;
  endtask

  task automatic nop();
    WB_i = 0; M_i = 0; addr_i = 0; data_i = 0; rd_i = 0;
  endtask

  logic [1:0]  cap_wb;
  logic        cap_we, cap_req;
  logic [31:0] cap_wdata;

  // Presents a memop until it retires; ack_at = cycle index of ack (0 = never)
  task automatic do_mem(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] a,
                        input logic [31:0] d, input logic [4:0] r, input int ack_at,
                        input logic [31:0] rdv, output int stalls);
    bit done;
    stalls = 0;
    done = 0;
    WB_i = wb; M_i = m; addr_i = a; data_i = d; rd_i = r;
    for (int i = 0; i < 40 && !done; i++) begin
      if (ack_at > 0 && i == ack_at) begin
        dmem_ack_i = 1; dmem_rdata_i = rdv;
      end
      @(negedge clk_i);
      if (stall_o) stalls++;
      if (i == 1) begin
        cap_wb = WB_o; cap_we = dmem_we_o; cap_wdata = dmem_wdata_o; cap_req = dmem_req_o;
      end
      if (i > 0 && !stall_o) done = 1;
      step();
      dmem_ack_i = 0;
    end
    if (!done) chk("mem_done_bound", {31'd0, done}, 32'd1);
    nop();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  int stalls;

  initial begin
    rst_i = 1; nop(); dmem_ack_i = 0; dmem_rdata_i = 0;
    repeat (3) @(posedge clk_i);
    #2;
    @(negedge clk_i);
    chk("rst_stall", stall_o, 0);
    chk("rst_req", dmem_req_o, 0);
    chk("rst_wb", WB_o, 0);
    chk("rst_rdata", rdata_o, 0);
    chk("rst_alu", alu_o, 0);
    chk("rst_err", err_o, 0);
    step(); rst_i = 0;

    step(); WB_i = 2'b10; addr_i = 32'h1234; rd_i = 5;
    @(negedge clk_i); chk("alu_stall", stall_o, 0);
    step(); nop();
    @(negedge clk_i);
    chk("alu_wb", WB_o, 2'b10);
    chk("alu_alu", alu_o, 32'h1234);
    chk("alu_rd", rd_o, 5);
    chk("alu_rdata", rdata_o, 0);

    step(); do_mem(2'b11, 3'b010, 32'h40, 32'h0, 5'd7, 3, 32'hDEADBEEF, stalls);
    @(negedge clk_i);
    chk("ld_stalls", stalls, 3);
    chk("ld_bubble", cap_wb, 0);
    chk("ld_wb", WB_o, 2'b11);
    chk("ld_rdata", rdata_o, 32'hDEADBEEF);
    chk("ld_alu", alu_o, 32'h40);
    chk("ld_rd", rd_o, 7);

    step(); do_mem(2'b00, 3'b001, 32'h80, 32'hA5A5A5A5, 5'd0, 1, 32'h12345678, stalls);
    @(negedge clk_i);
    chk("st_stalls", stalls, 1);
    chk("st_req", cap_req, 1);
    chk("st_we", cap_we, 1);
    chk("st_wdata", cap_wdata, 32'hA5A5A5A5);
    chk("st_rdata", rdata_o, 0);

    step(); do_mem(2'b10, 3'b111, 32'h84, 32'h11, 5'd9, 2, 32'hFFFFFFFF, stalls);
    @(negedge clk_i);
    chk("both_stalls", stalls, 2);
    chk("both_we", cap_we, 1);
    chk("both_rdata", rdata_o, 0);
    chk("both_wb", WB_o, 2'b10);

    step(); do_mem(2'b11, 3'b110, 32'h88, 32'h0, 5'd4, 1, 32'hCAFEF00D, stalls);
    @(negedge clk_i);
    chk("ld1_stalls", stalls, 1);
    chk("ld1_rdata", rdata_o, 32'hCAFEF00D);

    step(); do_mem(2'b11, 3'b010, 32'h90, 32'h0, 5'd6, 0, 32'h0, stalls);
    @(negedge clk_i);
    chk("tmo_stalls", stalls, TIMEOUT);
    chk("tmo_wb", WB_o, 0);
    chk("tmo_err", err_o, 1);
    chk("tmo_rdata", rdata_o, 0);
    step(); WB_i = 2'b10; addr_i = 32'h99; rd_i = 3;
    step(); nop();
    @(negedge clk_i);
    chk("tmo_next_wb", WB_o, 2'b10);
    chk("tmo_next_alu", alu_o, 32'h99);
    chk("tmo_sticky", err_o, 1);

    step(); WB_i = 2'b11; M_i = 3'b010; addr_i = 32'hA0; rd_i = 2;
    step(); step();
    rst_i = 1; nop();
    step();
    @(negedge clk_i);
    chk("rmid_req", dmem_req_o, 0);
    chk("rmid_wb", WB_o, 0);
    chk("rmid_err", err_o, 0);
    chk("rmid_stall", stall_o, 0);
    step(); rst_i = 0; dmem_ack_i = 1; dmem_rdata_i = 32'h55;
    step(); dmem_ack_i = 0;
    @(negedge clk_i);
    chk("late_wb", WB_o, 0);
    chk("late_req", dmem_req_o, 0);
    chk("late_rdata", rdata_o, 0);

`ifdef MEM_STALL_CNT_EN
    step(); do_mem(2'b11, 3'b010, 32'h10, 32'h0, 5'd1, 3, 32'h1, stalls);
    step(); do_mem(2'b11, 3'b010, 32'h14, 32'h0, 5'd2, 3, 32'h2, stalls);
    @(negedge clk_i);
    chk("cnt_six", stall_cnt_o, 6);
    step(); rst_i = 1;
    step(); rst_i = 0;
    @(negedge clk_i);
    chk("cnt_rst", stall_cnt_o, 0);
`endif

    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
